// File: rtl/mem_pkg.sv
// ============================================================================
// Module  : mem_pkg
// Purpose : Shared types and byte-lane merge helper for data_memory.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_pkg;

   typedef enum logic [0:0] {
      INIT = 1'b0,
      RUN  = 1'b1
   } mem_state_e;

   // Widest word index any legal DEPTH can need; unused upper bits stay zero.
   localparam int c_IDX_W = 30;

   typedef struct packed {
      logic               pv;
      logic [c_IDX_W-1:0] pidx;
      logic [31:0]        pdata;
      logic [3:0]         plane;
   } pend_t;

   function automatic logic [31:0] lane_merge(
      input logic [31:0] old_data,
      input logic [31:0] new_data,
      input logic [3:0]  lanes
   );
      logic [31:0] res;
      res = old_data;
      for (int i = 0; i < 4; i++) begin
         if (lanes[i]) res[8*i +: 8] = new_data[8*i +: 8];
      end
      return res;
   endfunction

endpackage

`default_nettype wire

// File: rtl/data_memory.sv
// ============================================================================
// Module  : data_memory
// Purpose : Zero-filled data memory with posted one-entry store buffer and
//           coherent same-cycle load overlay.
// Revision: 1.0
// ============================================================================
`default_nettype none

module data_memory #(
   parameter int DEPTH = 16384,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        chip_select,
   input  logic [3:0]  write_enable,
   input  logic        mem_read,
   input  logic [31:0] addr,
   input  logic [31:0] data_input,
   output logic [31:0] dout,
   output logic        ready,
   output logic        err
);
   import mem_pkg::*;

   localparam logic [AW-1:0] c_LAST = AW'(DEPTH - 1);

   mem_state_e    r_state;
   logic [AW-1:0] r_fill_cnt;
   pend_t         r_pend;
   logic          r_ready;
   logic          r_err;
   logic [31:0]   r_array [DEPTH];

   logic [AW-1:0] w_idx;
   logic          w_in_range;
   logic          w_run;
   logic          w_store;
   logic          w_load;
   logic          w_hit;
   logic [31:0]   w_rd_word;
   logic          w_unused;

   assign w_idx      = addr[AW+1:2];
   assign w_in_range = (addr[31:AW+2] == '0);
   assign w_run      = (r_state == RUN);
   assign w_store    = w_run && chip_select && (write_enable != 4'b0000) && w_in_range;
   assign w_load     = w_run && chip_select && mem_read && w_in_range;
   assign w_hit      = r_pend.pv && (r_pend.pidx == c_IDX_W'(w_idx));
   assign w_rd_word  = r_array[w_idx];
   // Byte offset is carried by the lane mask, not the address.
   assign w_unused   = ^addr[1:0];

   assign dout  = !w_load ? 32'h0 :
                  w_hit   ? lane_merge(w_rd_word, r_pend.pdata, r_pend.plane) :
                            w_rd_word;
   assign ready = r_ready;
   assign err   = r_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= INIT;
         r_fill_cnt <= '0;
         r_pend     <= '0;
         r_ready    <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         case (r_state)
            INIT: begin
               if (r_fill_cnt == c_LAST) begin
                  r_state <= RUN;
                  r_ready <= 1'b1;
               end else begin
                  r_fill_cnt <= r_fill_cnt + 1'b1;
               end
            end
            RUN: begin
               if (chip_select && !w_in_range) r_err <= 1'b1;
               // A new capture replaces the entry being drained this edge.
               if (w_store) begin
                  r_pend.pv    <= 1'b1;
                  r_pend.pidx  <= c_IDX_W'(w_idx);
                  r_pend.pdata <= data_input;
                  r_pend.plane <= write_enable;
               end else begin
                  r_pend.pv <= 1'b0;
               end
            end
            default: r_state <= INIT;
         endcase
      end
   end

   // Single write port shared between zero-fill and store drain.
   always_ff @(posedge clk) begin
      if (r_state == INIT) begin
         r_array[r_fill_cnt] <= 32'h0;
      end else if (r_pend.pv) begin
         r_array[r_pend.pidx[AW-1:0]] <= lane_merge(r_array[r_pend.pidx[AW-1:0]],
                                                    r_pend.pdata, r_pend.plane);
      end
   end

endmodule

`default_nettype wire
